// File: rtl/pcstackunit.sv
// pcstackunit -- program-counter unit with a hardware return-address stack.
//
// Drives the instruction-memory address (PC) from the strobes that
// instruction decode supplies. Call pushes the return address onto a small
// circular stack and Ret pops it back. Stall freezes all state. Overflow and
// Underflow are sticky error flags for the debug/status register.
//
// Parameters
//   PC_N   program-counter / immediate width in bits
//   DEPTH  return-stack entries (power of two, >= 2)
//
// Ports
//   Clock      in   sole clock, rising edge
//   Reset      in   synchronous, active-high
//   Stall      in   hold all state this cycle
//   Branch     in   PC <= PC + imm + 1
//   Jump       in   PC <= imm
//   Call       in   push PC + 1, PC <= imm
//   Ret        in   pop into PC
//   imm        in   [PC_N]  target / offset, unsigned, mod 2^PC_N
//   PC         out  [PC_N]  current program counter (registered)
//   Depth      out  [log2(DEPTH)+1]  valid stack entries, 0..DEPTH
//   Overflow   out  sticky, Call while full
//   Underflow  out  sticky, Ret while empty
//
// Action priority per cycle: Reset > Stall > Ret > Call > Jump > Branch > +1.

module pcstackunit #(
  parameter int PC_N  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic                     Branch,
  input  logic                     Jump,
  input  logic                     Call,
  input  logic                     Ret,
  input  logic [PC_N-1:0]          imm,
  output logic [PC_N-1:0]          PC,
  output logic [$clog2(DEPTH):0]   Depth,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int                 PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL  = (PTR_W + 1)'(DEPTH);

  logic [PC_N-1:0]  stack_mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_top;
  logic [PC_N-1:0]  pc_inc;
  logic [PC_N-1:0]  pc_br;
  logic             stack_empty;
  logic             stack_full;
  logic             do_ret;
  logic             do_call;

  // PC arithmetic truncates to PC_N bits, giving mod 2^PC_N wrap for free.
  assign pc_inc      = PC + 1'b1;
  assign pc_br       = PC + imm + 1'b1;
  // The pointer always names the next free slot, so the top lives one below.
  assign ptr_top     = ptr - 1'b1;
  assign stack_empty = (Depth == '0);
  assign stack_full  = (Depth == FULL);

  // Ret outranks Call; both are suppressed by Stall and Reset.
  assign do_ret  = !Reset && !Stall && Ret;
  assign do_call = !Reset && !Stall && !Ret && Call;

  // Control state: PC, pointer, occupancy and sticky flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      PC        <= '0;
      ptr       <= '0;
      Depth     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (!Stall) begin
      if (do_ret) begin
        if (stack_empty) begin
          // Empty pop behaves like a plain increment and records the error.
          PC        <= pc_inc;
          Underflow <= 1'b1;
        end else begin
          PC    <= stack_mem[ptr_top];
          ptr   <= ptr_top;
          Depth <= Depth - 1'b1;
        end
      end else if (do_call) begin
        PC  <= imm;
        ptr <= ptr + 1'b1;
        // When full, the pointer sits on the oldest entry, so the push
        // overwrites it and the stack keeps the newest DEPTH addresses.
        if (stack_full) begin
          Overflow <= 1'b1;
        end else begin
          Depth <= Depth + 1'b1;
        end
      end else if (Jump) begin
        PC <= imm;
      end else if (Branch) begin
        PC <= pc_br;
      end else begin
        PC <= pc_inc;
      end
    end
  end

  // Stack storage: data only, never reset.
  always_ff @(posedge Clock) begin
    if (do_call) begin
      stack_mem[ptr] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pcstackunit.sv
// Testbench for pcstackunit. Two instances share one stimulus stream:
// the default (PC_N=8, DEPTH=4) and a wider one (PC_N=12, DEPTH=8).
// Each has its own behavioural model and scoreboard queue; a monitor per
// instance pops the expected state after every clock edge and compares.

module tb_pcstackunit;

  typedef struct {
    int pc;
    int depth;
    int ovf;
    int unf;
  } exp_t;

  logic        Clock;
  logic        Reset, Stall, Branch, Jump, Call, Ret;
  logic [11:0] imm;

  logic [7:0]  pc0;
  logic [2:0]  depth0;
  logic        ovf0, unf0;
  logic [11:0] pc1;
  logic [3:0]  depth1;
  logic        ovf1, unf1;

  pcstackunit #(.PC_N(8), .DEPTH(4)) dut0 (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .Jump(Jump), .Call(Call), .Ret(Ret), .imm(imm[7:0]),
    .PC(pc0), .Depth(depth0), .Overflow(ovf0), .Underflow(unf0)
  );

  pcstackunit #(.PC_N(12), .DEPTH(8)) dut1 (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .Jump(Jump), .Call(Call), .Ret(Ret), .imm(imm),
    .PC(pc1), .Depth(depth1), .Overflow(ovf1), .Underflow(unf1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the stack is an ordered list, oldest first.
  int m_pc    [2];
  int m_cnt   [2];
  int m_ovf   [2];
  int m_unf   [2];
  int m_stk   [2][16];
  int m_w     [2] = '{8, 12};
  int m_dep   [2] = '{4, 8};

  exp_t sb0 [$];
  exp_t sb1 [$];

  task automatic model_step(input int k);
    int   mask;
    exp_t e;
    mask = (1 << m_w[k]) - 1;
    if (Reset) begin
      m_pc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end else if (Stall) begin
      // nothing changes
    end else if (Ret) begin
      if (m_cnt[k] > 0) begin
        m_cnt[k] = m_cnt[k] - 1;
        m_pc[k]  = m_stk[k][m_cnt[k]];
      end else begin
        m_pc[k]  = (m_pc[k] + 1) & mask;
        m_unf[k] = 1;
      end
    end else if (Call) begin
      if (m_cnt[k] == m_dep[k]) begin
        // Drop the oldest address, append the new one.
        for (int j = 0; j < m_dep[k] - 1; j++) m_stk[k][j] = m_stk[k][j+1];
        m_stk[k][m_dep[k]-1] = (m_pc[k] + 1) & mask;
        m_ovf[k] = 1;
      end else begin
        m_stk[k][m_cnt[k]] = (m_pc[k] + 1) & mask;
        m_cnt[k] = m_cnt[k] + 1;
      end
      m_pc[k] = int'(imm) & mask;
    end else if (Jump) begin
      m_pc[k] = int'(imm) & mask;
    end else if (Branch) begin
      m_pc[k] = (m_pc[k] + (int'(imm) & mask) + 1) & mask;
    end else begin
      m_pc[k] = (m_pc[k] + 1) & mask;
    end
    e.pc = m_pc[k]; e.depth = m_cnt[k]; e.ovf = m_ovf[k]; e.unf = m_unf[k];
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Drive one cycle's strobes, record the expected result, and return
  // just after the edge that consumes them.
  task automatic step(input bit r, input bit s, input bit rt, input bit c,
                      input bit j, input bit b, input logic [11:0] im);
    @(negedge Clock);
    Reset = r; Stall = s; Ret = rt; Call = c; Jump = j; Branch = b; imm = im;
    model_step(0);
    model_step(1);
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 12'h000);
  endtask

  // Monitors: compare DUT state with the scoreboard after every edge.
  exp_t e0, e1;

  always @(posedge Clock) begin
    #1;
    if (sb0.size() > 0) begin
      e0 = sb0.pop_front();
      check("pc8",    int'(pc0),    e0.pc);
      check("depth8", int'(depth0), e0.depth);
      check("ovf8",   int'(ovf0),   e0.ovf);
      check("unf8",   int'(unf0),   e0.unf);
    end
  end

  always @(posedge Clock) begin
    #1;
    if (sb1.size() > 0) begin
      e1 = sb1.pop_front();
      check("pc12",    int'(pc1),    e1.pc);
      check("depth12", int'(depth1), e1.depth);
      check("ovf12",   int'(ovf1),   e1.ovf);
      check("unf12",   int'(unf1),   e1.unf);
    end
  end

  initial begin
    int wait_cycles;
    Reset = 1; Stall = 0; Ret = 0; Call = 0; Jump = 0; Branch = 0; imm = '0;

    // Reset then count up.
    step(1, 0, 0, 0, 0, 0, 12'h000);
    check("reset_pc", int'(pc0), 0);
    repeat (5) idle();
    check("count5_pc", int'(pc0), 5);

    // Call / return round trip from 0x10.
    step(0, 0, 0, 0, 1, 0, 12'h010);
    step(0, 0, 0, 1, 0, 0, 12'h040);
    check("call_pc", int'(pc0), 'h40);
    idle(); idle();
    step(0, 0, 1, 0, 0, 0, 12'h000);
    check("ret_pc", int'(pc0), 'h11);

    // Nested calls beyond the 4-deep stack.
    step(1, 0, 0, 0, 0, 0, 12'h000);
    idle();
    step(0, 0, 0, 1, 0, 0, 12'h020); idle();
    step(0, 0, 0, 1, 0, 0, 12'h030); idle();
    step(0, 0, 0, 1, 0, 0, 12'h040); idle();
    step(0, 0, 0, 1, 0, 0, 12'h050); idle();
    step(0, 0, 0, 1, 0, 0, 12'h060);
    check("nest_ovf", int'(ovf0), 1);
    check("nest_depth", int'(depth0), 4);
    step(0, 0, 1, 0, 0, 0, 12'h000); check("ret1", int'(pc0), 'h52);
    step(0, 0, 1, 0, 0, 0, 12'h000); check("ret2", int'(pc0), 'h42);
    step(0, 0, 1, 0, 0, 0, 12'h000); check("ret3", int'(pc0), 'h32);
    step(0, 0, 1, 0, 0, 0, 12'h000); check("ret4", int'(pc0), 'h22);
    step(0, 0, 1, 0, 0, 0, 12'h000);
    check("ret5_pc", int'(pc0), 'h23);
    check("ret5_unf", int'(unf0), 1);

    // Wrap-around of branch and increment.
    step(0, 0, 0, 0, 1, 0, 12'h0F0);
    step(0, 0, 0, 0, 0, 1, 12'h020);
    check("br_wrap", int'(pc0), 'h11);
    step(0, 0, 0, 0, 1, 0, 12'h0FF);
    idle();
    check("inc_wrap", int'(pc0), 0);

    // Stall with conflicting strobes, then release with Jump.
    repeat (3) step(0, 1, 1, 1, 1, 1, 12'h077);
    check("stall_pc", int'(pc0), 0);
    step(0, 0, 0, 0, 1, 0, 12'h033);
    check("unstall_jump", int'(pc0), 'h33);

    // Ret + Call at depth 1: pop wins.
    step(1, 0, 0, 0, 0, 0, 12'h000);
    step(0, 0, 0, 1, 0, 0, 12'h040);
    step(0, 0, 1, 1, 0, 0, 12'h080);
    check("retcall_pc", int'(pc0), 1);
    check("retcall_depth", int'(depth0), 0);

    // Reset + Stall with depth 2 and Overflow set.
    repeat (5) step(0, 0, 0, 1, 0, 0, 12'h010);
    repeat (2) step(0, 0, 1, 0, 0, 0, 12'h000);
    step(1, 1, 0, 0, 0, 0, 12'h000);
    check("rststall_pc", int'(pc0), 0);
    check("rststall_depth", int'(depth0), 0);
    check("rststall_ovf", int'(ovf0), 0);

    // Wide instance: branch wraps mod 4096, overflow on the 9th Call.
    step(0, 0, 0, 0, 1, 0, 12'hFF0);
    step(0, 0, 0, 0, 0, 1, 12'h020);
    check("br_wrap12", int'(pc1), 'h011);
    step(1, 0, 0, 0, 0, 0, 12'h000);
    repeat (8) step(0, 0, 0, 1, 0, 0, 12'h100);
    check("ovf12_at8", int'(ovf1), 0);
    step(0, 0, 0, 1, 0, 0, 12'h200);
    check("ovf12_at9", int'(ovf1), 1);
    check("depth12_full", int'(depth1), 8);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           12'($urandom));
    end

    // Let the monitors drain the scoreboards.
    wait_cycles = 0;
    while ((sb0.size() > 0 || sb1.size() > 0) && wait_cycles < 10) begin
      @(posedge Clock);
      #2;
      wait_cycles++;
    end
    check("scoreboard_drained", sb0.size() + sb1.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pcstackunit.md
# pcstackunit

Parametrised program-counter unit, successor to the 8-bit PC sequencer. It adds a configurable PC width and a hardware return-address stack, so the control unit can issue subroutine Call and Ret. It also adds a pipeline Stall input, plus sticky stack-error flags for the debug/status register. It sits between instruction decode (which supplies the control strobes and immediate) and instruction memory (which is addressed by PC).

## Interface
Parameters:
- PC_N, default 8: program-counter and immediate width in bits.
- DEPTH, default 4: return-stack entries; power of two, at least 2.

Ports:
- Clock  input  1  sole clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hold all state this cycle.
- Branch  input  1  relative branch: PC + imm + 1.
- Jump  input  1  absolute jump: PC <= imm.
- Call  input  1  push PC + 1 onto the stack, then PC <= imm.
- Ret  input  1  pop the stack into PC.
- imm  input  PC_N  target or offset, unsigned; arithmetic is mod 2^PC_N.
- PC  output  PC_N  current program counter (registered).
- Depth  output  log2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
- Overflow  output  1  sticky; set by a Call while Depth == DEPTH.
- Underflow  output  1  sticky; set by a Ret while Depth == 0.

## Operation
- Per cycle, exactly one action is taken. Priority: Reset > Stall > Ret > Call > Jump > Branch > increment.
- Reset:
  - PC = 0, Depth = 0, Overflow = 0, Underflow = 0.
  - Stack pointer = 0; stack RAM contents are don't-care.
- Stall: PC, stack, Depth and both flags hold. All other strobes are ignored.
- Ret with Depth > 0:
  - PC <= top entry; Depth decrements.
- Ret with Depth == 0:
  - PC <= PC + 1; Depth stays 0; Underflow <= 1.
- Call with Depth < DEPTH:
  - Write PC + 1 (mod 2^PC_N) at the top; PC <= imm; Depth increments.
- Call with Depth == DEPTH (circular overwrite):
  - The pushed value replaces the oldest entry; the pointer wraps; Depth stays DEPTH; Overflow <= 1; PC <= imm.
  - The next DEPTH Rets return the newest DEPTH addresses in LIFO order.
- Jump: PC <= imm.
- Branch: PC <= PC + imm + 1, truncated to PC_N bits (wraps; no carry out).
- Otherwise: PC <= PC + 1, wrapping from 2^PC_N − 1 to 0.
- Flags are cleared only by Reset.
- Stack implementation:
  - Circular buffer of DEPTH × PC_N registers with a log2(DEPTH)-bit pointer.
  - Push writes at the pointer, then increments it; pop reads at pointer − 1, then decrements it.

## Timing
- All outputs are registered and change only on a rising Clock edge. Zero combinational path from inputs to outputs.
- Latency is one cycle: strobes sampled at edge n set PC visible after edge n.
- Call followed by Ret on the next cycle returns PC = (PC before the Call) + 1. There is no bypass hazard, because the push completes at the Call edge.
- Reset asserted mid-sequence (e.g. Depth = 3) clears everything at that edge. The first post-reset cycle increments from PC = 0.
- Reset has priority over Stall in the same cycle.
- Multiple strobes in one cycle resolve by the priority above. Example: Call + Jump acts as Call; the Jump is dropped.

## Test plan
- Reset, then 5 idle cycles → PC = 0,1,2,3,4,5; Depth = 0; both flags 0.
- At PC = 0x10: Call imm = 0x40, 2 idle cycles, then Ret → PC sequence 0x40, 0x41, 0x42, 0x11; Depth goes 1 then 0.
- Nested Calls from PC = 0x01, 0x21, 0x31, 0x41, 0x51 (imm = 0x20, 0x30, 0x40, 0x50, 0x60) with DEPTH = 4 →
  - After the 5th Call: Overflow = 1, Depth = 4.
  - Four Rets give 0x52, 0x42, 0x32, 0x22.
  - A 5th Ret gives PC + 1 and sets Underflow = 1.
- Wrap-around: PC = 0xF0, Branch imm = 0x20 → PC = 0x11. PC = 0xFF idle → PC = 0x00.
- Stall held 3 cycles with Call, Jump and Ret all asserted → PC, Depth and flags unchanged. Release with Jump imm = 0x33 → PC = 0x33.
- Simultaneous events and reset:
  - Ret + Call with Depth = 1 → pop wins.
  - Reset + Stall with Depth = 2 and Overflow = 1 → all outputs 0 next cycle.
  - Rerun with PC_N = 12, DEPTH = 8 → Branch wraps mod 4096; overflow occurs on the 9th Call.
